// File: rtl/shift_lr.sv
// 32-bit bidirectional barrel shifter: logical left, logical right and
// arithmetic right by 0..WIDTH-1, with a combinational result and a registered copy.

// One log-stage of the right-shift core: shift by AMT when sel is set,
// filling the vacated MSBs with fill.
module shift_lr_stage #(
   parameter int WIDTH = 32,
   parameter int AMT   = 1
) (
   input  logic [WIDTH-1:0] din,
   input  logic             sel,
   input  logic             fill,
   output logic [WIDTH-1:0] dout
);

   always_comb begin
      dout = din;
      if (sel) dout = {{AMT{fill}}, din[WIDTH-1:AMT]};
   end

endmodule

module shift_lr #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] X,
   input  logic [SHW-1:0]   S,
   input  logic             LEFT,
   input  logic             LOG,
   output logic [WIDTH-1:0] Z,
   output logic [WIDTH-1:0] Z_R
);

   logic [WIDTH-1:0]          x_rev;
   logic [WIDTH-1:0]          core_in;
   logic [WIDTH-1:0]          core_out;
   logic [WIDTH-1:0]          core_rev;
   logic [SHW:0][WIDTH-1:0]   stg;
   logic                      fill;

   // Left shifts run through the same right-shift core on bit-reversed data.
   for (genvar i = 0; i < WIDTH; i++) begin : g_rev
      assign x_rev[i]    = X[WIDTH-1-i];
      assign core_rev[i] = core_out[WIDTH-1-i];
   end

   assign fill    = X[WIDTH-1] & ~LOG & ~LEFT;
   assign core_in = LEFT ? x_rev : X;
   assign stg[0]  = core_in;

   for (genvar k = 0; k < SHW; k++) begin : g_stage
      shift_lr_stage #(
         .WIDTH (WIDTH),
         .AMT   (1 << k)
      ) u_stage (
         .din   (stg[k]),
         .sel   (S[k]),
         .fill  (fill),
         .dout  (stg[k+1])
      );
   end

   assign core_out = stg[SHW];
   assign Z        = LEFT ? core_rev : core_out;

   always_ff @(posedge clk) begin
      if (rst) Z_R <= '0;
      else     Z_R <= Z;
   end

endmodule

// File: tb/tb_shift_lr.sv
// Scoreboard bench for shift_lr: expected Z / Z_R queued at drive time, checked 1ns after each rising edge.
module tb_shift_lr;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] X;
   logic [4:0]  S;
   logic        LEFT;
   logic        LOG;
   logic [31:0] Z;
   logic [31:0] Z_R;

   int total = 0;
   int bad   = 0;
   bit done  = 1'b0;

   logic [31:0] qz[$];
   logic [31:0] qzr[$];
   string       qt[$];

   shift_lr dut (
      .clk  (clk),
      .rst  (rst),
      .X    (X),
      .S    (S),
      .LEFT (LEFT),
      .LOG  (LOG),
      .Z    (Z),
      .Z_R  (Z_R)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_shift(input logic [31:0] x, input logic [4:0] s,
                                             input logic l, input logic g);
      if (l)      return x << s;
      else if (g) return x >> s;
      else        return 32'($signed(x) >>> s);
   endfunction

   // Drive one vector for a full cycle and queue what the DUT must show after the next edge.
   task automatic drive(input string tag, input logic r, input logic [31:0] x, input logic [4:0] s,
                        input logic l, input logic g, input logic [31:0] exp_z);
      @(negedge clk);
      rst = r; X = x; S = s; LEFT = l; LOG = g;
      qz.push_back(exp_z);
      qzr.push_back(r ? 32'h0 : exp_z);
      qt.push_back(tag);
   endtask

   task automatic apply(input string tag, input logic [31:0] x, input logic [4:0] s,
                        input logic l, input logic g);
      drive(tag, 1'b0, x, s, l, g, ref_shift(x, s, l, g));
   endtask

   initial begin : monitor
      forever begin
         @(posedge clk);
         #1;
         if (qz.size() > 0) begin
            string t;
            logic [31:0] ez, ezr;
            t   = qt.pop_front();
            ez  = qz.pop_front();
            ezr = qzr.pop_front();
            chk({t, ".z"},  Z,   ez);
            chk({t, ".zr"}, Z_R, ezr);
         end
      end
   end

   initial begin : stim
      logic [31:0] d;
      rst = 1'b1; X = '0; S = '0; LEFT = 1'b0; LOG = 1'b0;
      d = 32'hDEADBEEF;

      // reset state and registered-output sequence
      drive("rst0", 1'b1, d, 5'd0, 1'b0, 1'b0, d);
      drive("zr_load", 1'b0, 32'h12345678, 5'd8, 1'b1, 1'b0, 32'h34567800);
      drive("zr_hold", 1'b0, 32'h12345678, 5'd8, 1'b1, 1'b0, 32'h34567800);
      drive("zr_rst",  1'b1, 32'h12345678, 5'd8, 1'b1, 1'b0, 32'h34567800);
      drive("zr_rel",  1'b0, 32'h12345678, 5'd8, 1'b1, 1'b0, 32'h34567800);

      for (int s = 0; s < 32; s++) apply($sformatf("asr_s%0d", s), $urandom | 32'h8000_0000 * (s % 2), 5'(s), 1'b0, 1'b0);
      drive("asr_dir", 1'b0, 32'h80000000, 5'd4, 1'b0, 1'b0, 32'hF8000000);

      for (int s = 0; s < 32; s++) apply($sformatf("lsr_s%0d", s), $urandom | 32'h8000_0000 * (s % 2), 5'(s), 1'b0, 1'b1);
      drive("lsr_dir", 1'b0, 32'h80000000, 5'd4, 1'b0, 1'b1, 32'h08000000);

      for (int g = 1; g >= 0; g--)
         for (int s = 0; s < 32; s++) apply($sformatf("lsl%0d_s%0d", g, s), $urandom, 5'(s), 1'b1, 1'(g));
      drive("lsl_dir31", 1'b0, 32'h00000001, 5'd31, 1'b1, 1'b1, 32'h80000000);
      drive("lsl_dir1",  1'b0, 32'hC0000001, 5'd1,  1'b1, 1'b0, 32'h80000002);

      for (int m = 0; m < 4; m++)
         drive($sformatf("s0_m%0d", m), 1'b0, d, 5'd0, 1'(m >> 1), 1'(m & 1), d);
      drive("s31_asr", 1'b0, d, 5'd31, 1'b0, 1'b0, 32'hFFFFFFFF);
      drive("s31_lsr", 1'b0, d, 5'd31, 1'b0, 1'b1, 32'h00000001);
      drive("s31_lsl", 1'b0, d, 5'd31, 1'b1, 1'b0, 32'h80000000);
      drive("s31_asr_pos", 1'b0, 32'h7FFFFFFF, 5'd31, 1'b0, 1'b0, 32'h00000000);

      repeat (3) @(posedge clk);
      #2;
      chk("drain", 32'(qz.size()), 32'h0);
      done = 1'b1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #100000;
      if (!done) begin
         $display("FAIL timeout got=running exp=finished");
         $fatal(1);
      end
   end

endmodule

// File: doc/shift_lr.md
Name: shift_lr

Overview:
- 32-bit bidirectional barrel shifter for the Mosaic functional unit.
- Supports logical left, logical right and arithmetic right shifts by 0–31 bit positions.
- The primary result is combinational, with zero latency.
- A registered copy of the result is also provided for pipelined consumers elsewhere in the functional unit.

Parameters:
- WIDTH, 32, data width. Only 32 is required to be supported.
- SHW, 5, shift-amount width. Must equal log2(WIDTH).

Ports:
- clk  input  1  clock; rising-edge active.
- rst  input  1  synchronous, active-high reset; affects only Z_R.
- X  input  32  operand, treated as signed for arithmetic right shifts.
- S  input  5  shift amount, unsigned, 0–31.
- LEFT  input  1  1 = shift left, 0 = shift right.
- LOG  input  1  1 = logical, 0 = arithmetic. Only affects right shifts.
- Z  output  32  combinational shift result.
- Z_R  output  32  Z registered on the rising edge of clk.

Behaviour:
- Z is a pure combinational function of X, S, LEFT and LOG. There are no internal state effects on Z, and clk and rst do not affect it.
- LEFT=1, regardless of LOG: Z = X << S. Vacated LSBs are filled with 0. Arithmetic left shift and logical left shift give the same result.
- LEFT=0, LOG=1: Z = X >> S. Vacated MSBs are filled with 0.
- LEFT=0, LOG=0: Z = X >>> S. Vacated MSBs are filled with X[31].
- S=0: Z = X for all modes.
- S=31:
  - Left: Z = {X[0], 31'b0}.
  - Logical right: Z = {31'b0, X[31]}.
  - Arithmetic right: all 32 bits equal X[31].
- Z must settle within one clock period after any input change. The bench samples Z at the rising edge using the inputs that were stable during the preceding cycle.
- There are no X/Z-propagation special cases. With known inputs, every output bit must be 0 or 1, with no unknown values.
- Required structure: a log-stage barrel shifter with 5 mux stages (shift by 1, 2, 4, 8, 16), one per bit of S.
  - Left shifts use bit-reversal of X on input and of the result on output around a single right-shift core.
  - The core fill bit is X[31] & ~LOG & ~LEFT.
  - A duplicated left/right mux tree is also acceptable, provided results are identical.
- Z_R:
  - On each rising edge of clk: if rst=1, Z_R <= 32'h0; otherwise Z_R <= Z.
  - Latency is 1 cycle.
  - Z_R is 32'h0 after the first clock edge with rst asserted.
  - Asserting rst mid-stream clears Z_R on the next edge only. Z is unaffected.
- Z_R has no enable; it updates every cycle.

Test Plan:
- Arithmetic right, sweep: S = 0..31 incrementing, random X, LEFT=0, LOG=0 -> Z === X>>>S every cycle. Directed case: X=32'h80000000, S=4 -> Z=32'hF8000000.
- Logical right, sweep: S = 0..31 incrementing, random X, LEFT=0, LOG=1 -> Z === X>>S. Directed case: X=32'h80000000, S=4 -> Z=32'h08000000.
- Left shift, sweep: S = 0..31 incrementing, random X, LEFT=1, LOG=1 then LOG=0 -> Z === X<<S in both modes. Directed cases:
  - X=32'h00000001, S=31 -> Z=32'h80000000.
  - X=32'hC0000001, S=1 -> Z=32'h80000002.
- Boundaries, with X=32'hDEADBEEF:
  - S=0, all four mode combinations -> Z=32'hDEADBEEF.
  - S=31, LEFT=0, LOG=0 -> Z=32'hFFFFFFFF.
  - S=31, LEFT=0, LOG=1 -> Z=32'h00000001.
- Registered output:
  - rst=1 for one edge -> Z_R=32'h0.
  - Release rst, apply X=32'h12345678, S=8, LEFT=1 -> Z=32'h34567800 immediately, and Z_R=32'h34567800 after the next rising edge.
  - Reassert rst -> Z_R=32'h0 on the following edge while Z is unchanged.
